// File: rtl/m_board_state.sv
// m_board_state: Connect-Four board keeper (7 columns x 6 rows).
// Accepts one move per handshake and checks it for legality. Legal moves are dropped into the
// chosen column. The four line directions through the new piece are then checked, one per
// cycle, and the result is resolved as a win, a draw or a hand-over of the turn.
//
// Ports
//   w_clk, w_rst      clock; asynchronous active-high reset
//   w_new_game        synchronous clear back to the reset state (wins over a same-cycle move)
//   i_move_valid      move request, taken when i_move_valid & o_move_ready
//   i_move_col        target column 0..6
//   i_move_is_me      side issuing the move (1 = me, 0 = op)
//   o_move_ready      high in IDLE only
//   o_me_field/o_op_field  occupancy, bit = row*7 + col, row 0 at the bottom
//   o_piled_array     column heights, column c at [3c+2:3c]
//   o_turn_me         side to move next
//   o_board_valid     board stable for consumers (same as o_move_ready)
//   o_move_rejected   one-cycle pulse for an illegal move
//   o_winner          00 none, 01 me, 10 op, 11 draw
//   o_game_over       o_winner != 00
module m_board_state #(
  parameter bit ME_FIRST = 1'b1
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_new_game,
  input  logic        i_move_valid,
  input  logic [2:0]  i_move_col,
  input  logic        i_move_is_me,
  output logic        o_move_ready,
  output logic [41:0] o_me_field,
  output logic [41:0] o_op_field,
  output logic [20:0] o_piled_array,
  output logic        o_turn_me,
  output logic        o_board_valid,
  output logic        o_move_rejected,
  output logic [1:0]  o_winner,
  output logic        o_game_over
);

  localparam int unsigned NumCols  = 7;
  localparam int unsigned NumRows  = 6;
  localparam int unsigned NumCells = NumCols * NumRows;

  typedef enum logic [2:0] {
    StIdle,
    StReject,
    StPlace,
    StCheck,
    StResolve,
    StOver
  } state_e;

  state_e      state_q;
  logic [41:0] me_field_q;
  logic [41:0] op_field_q;
  logic [20:0] piled_q;
  logic        turn_me_q;
  logic [1:0]  winner_q;
  logic        rejected_q;
  logic [5:0]  move_cnt_q;
  logic [2:0]  col_q;      // column of the move in flight
  logic [2:0]  row_q;      // row it lands in (column height at accept)
  logic        mover_q;
  logic [1:0]  dir_q;      // CHECK direction: horiz, vert, up-right, up-left
  logic        win_q;

  // Cell lookup with everything off the board reading as empty, so a line never
  // wraps from column 6 of one row into column 0 of the next.
  function automatic logic cell_set(input logic [41:0] f, input int r, input int c);
    logic [5:0] idx;
    if (r < 0 || r >= int'(NumRows) || c < 0 || c >= int'(NumCols)) return 1'b0;
    idx = 6'(r * int'(NumCols) + c);
    return f[idx];
  endfunction

  // Height of the requested column; column 7 reads as 0 and is rejected separately.
  logic [2:0] sel_height;
  logic       move_illegal;

  always_comb begin
    sel_height = 3'd0;
    for (int c = 0; c < int'(NumCols); c++) begin
      if (i_move_col == 3'(c)) sel_height = piled_q[3*c +: 3];
    end
    move_illegal = (i_move_col > 3'd6) || (sel_height == 3'(NumRows)) ||
                   (i_move_is_me != turn_me_q);
  end

  // Contiguous run of the mover's pieces through the placed cell along dir_q.
  logic [41:0] mover_field;
  int          step_r;
  int          step_c;
  logic        fwd_ok;
  logic        bwd_ok;
  logic [2:0]  run_len;

  assign mover_field = mover_q ? me_field_q : op_field_q;

  always_comb begin
    step_r = 0;
    step_c = 1;
    unique case (dir_q)
      2'd0: begin step_r = 0; step_c = 1;  end
      2'd1: begin step_r = 1; step_c = 0;  end
      2'd2: begin step_r = 1; step_c = 1;  end
      2'd3: begin step_r = 1; step_c = -1; end
    endcase
    run_len = 3'd1;
    fwd_ok  = 1'b1;
    bwd_ok  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      if (fwd_ok && cell_set(mover_field, int'(row_q) + k * step_r, int'(col_q) + k * step_c))
        run_len = run_len + 3'd1;
      else
        fwd_ok = 1'b0;
      if (bwd_ok && cell_set(mover_field, int'(row_q) - k * step_r, int'(col_q) - k * step_c))
        run_len = run_len + 3'd1;
      else
        bwd_ok = 1'b0;
    end
  end

  logic [5:0] place_idx;
  assign place_idx = 6'(row_q) * 6'd7 + 6'(col_q);

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q    <= StIdle;
      me_field_q <= '0;
      op_field_q <= '0;
      piled_q    <= '0;
      turn_me_q  <= ME_FIRST;
      winner_q   <= 2'b00;
      rejected_q <= 1'b0;
      move_cnt_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      mover_q    <= 1'b0;
      dir_q      <= '0;
      win_q      <= 1'b0;
    end else if (w_new_game) begin
      state_q    <= StIdle;
      me_field_q <= '0;
      op_field_q <= '0;
      piled_q    <= '0;
      turn_me_q  <= ME_FIRST;
      winner_q   <= 2'b00;
      rejected_q <= 1'b0;
      move_cnt_q <= '0;
      dir_q      <= '0;
      win_q      <= 1'b0;
    end else begin
      rejected_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_move_valid) begin
            col_q   <= i_move_col;
            row_q   <= sel_height;
            mover_q <= i_move_is_me;
            if (move_illegal) begin
              rejected_q <= 1'b1;
              state_q    <= StReject;
            end else begin
              state_q <= StPlace;
            end
          end
        end
        StReject: state_q <= StIdle;
        StPlace: begin
          if (mover_q) me_field_q <= me_field_q | (42'd1 << place_idx);
          else         op_field_q <= op_field_q | (42'd1 << place_idx);
          for (int c = 0; c < int'(NumCols); c++) begin
            if (col_q == 3'(c)) piled_q[3*c +: 3] <= piled_q[3*c +: 3] + 3'd1;
          end
          move_cnt_q <= move_cnt_q + 6'd1;
          dir_q      <= 2'd0;
          win_q      <= 1'b0;
          state_q    <= StCheck;
        end
        StCheck: begin
          if (run_len >= 3'd4) win_q <= 1'b1;
          dir_q <= dir_q + 2'd1;
          if (dir_q == 2'd3) state_q <= StResolve;
        end
        StResolve: begin
          if (win_q) begin
            winner_q <= mover_q ? 2'b01 : 2'b10;
            state_q  <= StOver;
          end else if (move_cnt_q == 6'(NumCells)) begin
            winner_q <= 2'b11;
            state_q  <= StOver;
          end else begin
            turn_me_q <= ~turn_me_q;
            state_q   <= StIdle;
          end
        end
        StOver: state_q <= StOver;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_move_ready    = (state_q == StIdle);
  assign o_board_valid   = o_move_ready;
  assign o_me_field      = me_field_q;
  assign o_op_field      = op_field_q;
  assign o_piled_array   = piled_q;
  assign o_turn_me       = turn_me_q;
  assign o_move_rejected = rejected_q;
  assign o_winner        = winner_q;
  assign o_game_over     = (winner_q != 2'b00);

endmodule

// File: tb/tb_m_board_state.sv
module tb_m_board_state;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_game;
  logic        valid;
  logic [2:0]  mcol;
  logic        is_me;
  logic        ready;
  logic [41:0] me_field;
  logic [41:0] op_field;
  logic [20:0] piled;
  logic        turn_me;
  logic        board_valid;
  logic        rejected;
  logic [1:0]  winner;
  logic        game_over;

  always #5 clk = ~clk;

  m_board_state #(.ME_FIRST(1'b1)) dut (
    .w_clk          (clk),
    .w_rst          (rst),
    .w_new_game     (new_game),
    .i_move_valid   (valid),
    .i_move_col     (mcol),
    .i_move_is_me   (is_me),
    .o_move_ready   (ready),
    .o_me_field     (me_field),
    .o_op_field     (op_field),
    .o_piled_array  (piled),
    .o_turn_me      (turn_me),
    .o_board_valid  (board_valid),
    .o_move_rejected(rejected),
    .o_winner       (winner),
    .o_game_over    (game_over)
  );

  typedef struct {
    logic        rej;
    logic [41:0] me;
    logic [41:0] op;
    logic [20:0] piled;
    logic        turn;
    logic [1:0]  win;
  } exp_t;

  typedef struct {
    logic       me;
    logic [2:0] col;
    logic       rej;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_bad = 0;

  // Reference board
  logic [41:0] m_me;
  logic [41:0] m_op;
  int          m_ht[8];
  logic        m_turn;
  logic [1:0]  m_win;
  int          m_moves;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_me = '0;
    m_op = '0;
    for (int i = 0; i < 8; i++) m_ht[i] = 0;
    m_turn  = 1'b1;
    m_win   = 2'b00;
    m_moves = 0;
    sb_q.delete();
  endtask

  function automatic logic [20:0] model_piled();
    logic [20:0] p;
    p = '0;
    for (int c = 0; c < 7; c++) p[3*c +: 3] = 3'(m_ht[c]);
    return p;
  endfunction

  // Global scan for any four in a row.
  function automatic logic four_in_row(input logic [41:0] f);
    int dr[4];
    int dc[4];
    int rr;
    int cc;
    logic ok;
    dr = '{0, 1, 1, 1};
    dc = '{1, 0, 1, -1};
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        for (int d = 0; d < 4; d++) begin
          ok = 1'b1;
          for (int k = 0; k < 4; k++) begin
            rr = r + k * dr[d];
            cc = c + k * dc[d];
            if (rr < 0 || rr > 5 || cc < 0 || cc > 6) ok = 1'b0;
            else if (!f[6'(rr * 7 + cc)]) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic check_board(input string tag, input exp_t e);
    check({tag, ":me_field"}, 64'(me_field), 64'(e.me));
    check({tag, ":op_field"}, 64'(op_field), 64'(e.op));
    check({tag, ":piled"}, 64'(piled), 64'(e.piled));
  endtask

  task automatic apply_move(input logic me, input logic [2:0] c, input logic exp_rej,
                            input string tag);
    exp_t e;
    int   t;
    int   idx;
    t = 0;
    while (!ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!ready) begin
      check({tag, ":ready_wait"}, 64'(ready), 64'(1));
      return;
    end
    if (!exp_rej) begin
      idx = m_ht[c] * 7 + int'(c);
      if (me) m_me[idx] = 1'b1;
      else    m_op[idx] = 1'b1;
      m_ht[c]++;
      m_moves++;
      if (four_in_row(me ? m_me : m_op)) m_win = me ? 2'b01 : 2'b10;
      else if (m_moves == 42)            m_win = 2'b11;
      else                               m_turn = ~m_turn;
    end
    e.rej   = exp_rej;
    e.me    = m_me;
    e.op    = m_op;
    e.piled = model_piled();
    e.turn  = m_turn;
    e.win   = m_win;
    sb_q.push_back(e);
    valid = 1'b1;
    is_me = me;
    mcol  = c;
    @(posedge clk); #1;  // T+1
    valid = 1'b0;
    check({tag, ":rejected"}, 64'(rejected), 64'(exp_rej));
    e = sb_q.pop_front();
    if (exp_rej) begin
      @(posedge clk); #1;  // T+2
    end else begin
      @(posedge clk); #1;  // T+2: board already updated
      check_board({tag, ":t2"}, e);
      repeat (5) begin
        @(posedge clk); #1;
      end                   // T+7
    end
    check_board(tag, e);
    check({tag, ":turn"}, 64'(turn_me), 64'(e.turn));
    check({tag, ":winner"}, 64'(winner), 64'(e.win));
    check({tag, ":game_over"}, 64'(game_over), 64'(e.win != 2'b00));
    check({tag, ":ready"}, 64'(ready), 64'(e.win == 2'b00));
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    model_reset();
    check("new_game:ready", 64'(ready), 64'(1));
    check("new_game:winner", 64'(winner), 64'(0));
    check("new_game:me_field", 64'(me_field), 64'(0));
  endtask

  task automatic play_list(input int cols[], input string tag);
    foreach (cols[i]) apply_move(m_turn, 3'(cols[i]), 1'b0, tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    int   vert[7];
    int   diag[10];
    int   wrap[7];
    int   draw[42];
    int   pairs[3][2];
    int   pat[12];
    int   n;

    // After me plays col 3, op is to move.
    vecs = '{
      '{me: 1'b1, col: 3'd2, rej: 1'b1},   // wrong side
      '{me: 1'b0, col: 3'd7, rej: 1'b1},   // no column 7
      '{me: 1'b0, col: 3'd0, rej: 1'b0},
      '{me: 1'b1, col: 3'd0, rej: 1'b0},
      '{me: 1'b0, col: 3'd0, rej: 1'b0},
      '{me: 1'b1, col: 3'd0, rej: 1'b0},
      '{me: 1'b0, col: 3'd0, rej: 1'b0},
      '{me: 1'b1, col: 3'd0, rej: 1'b0},
      '{me: 1'b0, col: 3'd0, rej: 1'b1},   // column full
      '{me: 1'b1, col: 3'd5, rej: 1'b1}    // wrong side
    };
    vert = '{0, 1, 0, 1, 0, 1, 0};
    diag = '{1, 0, 2, 1, 3, 2, 3, 2, 3, 3};
    wrap = '{5, 0, 6, 1, 0, 3, 1};
    // Final board colour = ((c + 2r) mod 4) < 2 has no line of four for either side.
    pairs = '{'{1, 2}, '{4, 3}, '{5, 6}};
    pat   = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0};
    for (int i = 0; i < 6; i++) draw[i] = 0;
    n = 6;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 12; i++) begin
        draw[n] = pairs[p][pat[i]];
        n++;
      end

    rst = 1'b1; new_game = 1'b0; valid = 1'b0; mcol = '0; is_me = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset:me_field", 64'(me_field), 64'(0));
    check("reset:op_field", 64'(op_field), 64'(0));
    check("reset:piled", 64'(piled), 64'(0));
    check("reset:winner", 64'(winner), 64'(0));
    check("reset:game_over", 64'(game_over), 64'(0));
    check("reset:rejected", 64'(rejected), 64'(0));
    check("reset:turn", 64'(turn_me), 64'(1));
    rst = 1'b0;
    #1;
    check("reset:ready", 64'(ready), 64'(1));
    check("reset:board_valid", 64'(board_valid), 64'(1));
    model_reset();

    apply_move(1'b1, 3'd3, 1'b0, "single");
    check("single:bit3", 64'(me_field[3]), 64'(1));
    check("single:h3", 64'(piled[11:9]), 64'(1));
    check("single:turn_op", 64'(turn_me), 64'(0));

    for (int i = 0; i < 10; i++) apply_move(vecs[i].me, vecs[i].col, vecs[i].rej, "vec");

    // New game beats a move accepted in the same cycle.
    valid = 1'b1; is_me = m_turn; mcol = 3'd2; new_game = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; new_game = 1'b0;
    model_reset();
    check("ng_prio:ready", 64'(ready), 64'(1));
    check("ng_prio:rejected", 64'(rejected), 64'(0));
    check("ng_prio:op_field", 64'(op_field), 64'(0));
    check("ng_prio:turn", 64'(turn_me), 64'(1));
    @(posedge clk); #1;
    check("ng_prio:still_idle", 64'(ready), 64'(1));
    check("ng_prio:piled", 64'(piled), 64'(0));

    play_list(vert, "vert");
    check("vert:winner_me", 64'(winner), 64'(2'b01));
    valid = 1'b1; is_me = 1'b0; mcol = 3'd2;
    repeat (4) begin
      @(posedge clk); #1;
      check("over:no_pulse", 64'(rejected), 64'(0));
    end
    valid = 1'b0;
    check("over:op_field", 64'(op_field), 64'(m_op));
    check("over:ready", 64'(ready), 64'(0));
    check("over:winner", 64'(winner), 64'(2'b01));

    pulse_new_game();
    play_list(diag, "diag");
    check("diag:winner_op", 64'(winner), 64'(2'b10));

    pulse_new_game();
    play_list(wrap, "wrap");
    check("wrap:no_win", 64'(winner), 64'(0));

    // Asynchronous reset in the middle of CHECK.
    valid = 1'b1; is_me = m_turn; mcol = 3'd4;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("arst:me_field", 64'(me_field), 64'(0));
    check("arst:op_field", 64'(op_field), 64'(0));
    check("arst:piled", 64'(piled), 64'(0));
    check("arst:turn", 64'(turn_me), 64'(1));
    check("arst:winner", 64'(winner), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    model_reset();
    check("arst:ready", 64'(ready), 64'(1));

    play_list(draw, "draw");
    check("draw:winner", 64'(winner), 64'(2'b11));
    check("draw:game_over", 64'(game_over), 64'(1));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
